// File: rtl/seq_divider_if.sv
// Request/response bundle between an execute-stage master and the iterative divider.
// The master drives the operands and start; the divider returns status and results.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock on operand magnitudes,
// followed by a single sign-fix cycle. Signed mode truncates toward zero.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    seq_divider_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH-1:0] rem_reg;
    logic             dvd_neg_reg;
    logic             dvs_neg_reg;
    logic             zero_reg;
    logic             done_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             div_by_zero_reg;

    logic             dvd_neg_in, dvs_neg_in;
    logic [WIDTH-1:0] dvd_mag_in, dvs_mag_in;
    logic [WIDTH:0]   shifted, trial;

    // The most-negative value negates to itself, which is exactly its unsigned magnitude.
    assign dvd_neg_in = bus.is_signed & bus.dividend[WIDTH-1];
    assign dvs_neg_in = bus.is_signed & bus.divisor[WIDTH-1];
    assign dvd_mag_in = dvd_neg_in ? -bus.dividend : bus.dividend;
    assign dvs_mag_in = dvs_neg_in ? -bus.divisor  : bus.divisor;

    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the trial result.
    assign shifted = {rem_reg, dvd_reg[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_reg};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (count_reg == LAST_ITER) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg       <= '0;
            dvd_reg         <= '0;
            dvs_reg         <= '0;
            rem_reg         <= '0;
            dvd_neg_reg     <= 1'b0;
            dvs_neg_reg     <= 1'b0;
            zero_reg        <= 1'b0;
            done_reg        <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            div_by_zero_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        dvd_reg     <= dvd_mag_in;
                        dvs_reg     <= dvs_mag_in;
                        dvd_neg_reg <= dvd_neg_in;
                        dvs_neg_reg <= dvs_neg_in;
                        zero_reg    <= (bus.divisor == '0);
                        rem_reg     <= '0;
                        count_reg   <= '0;
                    end
                end
                RUN: begin
                    rem_reg   <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    dvd_reg   <= {dvd_reg[WIDTH-2:0], ~trial[WIDTH]};
                    count_reg <= count_reg + 1'b1;
                end
                FIX: begin
                    // Re-applying the dividend sign to the remainder also restores the
                    // original dividend on a zero divisor, so only the quotient is special-cased.
                    quotient_reg    <= zero_reg ? '1
                                     : ((dvd_neg_reg ^ dvs_neg_reg) ? -dvd_reg : dvd_reg);
                    remainder_reg   <= dvd_neg_reg ? -rem_reg : rem_reg;
                    div_by_zero_reg <= zero_reg;
                    done_reg        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = done_reg;
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = div_by_zero_reg;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expectations are queued at issue time and
// compared (values and latency) whenever done pulses.
module tb_seq_divider;
    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             s;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             z;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_accept = 0;
    exp_t sb[$];

    seq_divider_if #(.WIDTH(WIDTH)) bus ();

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        exp_t e;
        logic [WIDTH-1:0] most_neg;
        most_neg = {1'b1, {(WIDTH-1){1'b0}}};
        e.a = a; e.b = b; e.s = s;
        e.z = (b == '0);
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else if (s && a == most_neg && b == '1) begin
            e.q = most_neg;
            e.r = '0;
        end else if (s) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Record the edge on which the divider accepts a request.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && bus.start && !bus.busy) last_accept <= cyc + 1;
    end

    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn %s %0h / %0h -> q=%0h r=%0h dz=%0b (exp q=%0h r=%0h dz=%0b)",
                         e.s ? "signed" : "unsigned", e.a, e.b,
                         bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.z);
                check("quotient", bus.quotient, e.q);
                check("remainder", bus.remainder, e.r);
                check("div_by_zero", bus.div_by_zero, e.z);
                check("latency", cyc - last_accept, WIDTH + 1);
                check("busy_at_done", bus.busy, 0);
            end
        end
    end

    // Called at a negedge: drive a request for one cycle and queue its expectation.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                         input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r, input logic z);
        exp_t e;
        e.a = a; e.b = b; e.s = s; e.q = q; e.r = r; e.z = z;
        sb.push_back(e);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b; bus.is_signed = s;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
    endtask

    task automatic issue_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        exp_t e;
        e = model(a, b, s);
        issue(a, b, s, e.q, e.r, e.z);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.done && n < WIDTH + 10) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) check("done_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got=stuck expected=finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [WIDTH-1:0] a, b;
        reset = 1'b1;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_dz", bus.div_by_zero, 0);
        @(negedge clk);

        issue(100, 7, 1'b0, 14, 2, 1'b0);
        repeat (WIDTH - 1) @(negedge clk);
        check("busy_before_done", bus.busy, 1);
        wait_done();
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        check("hold_quotient", bus.quotient, 14);

        issue(-32'sd7, 2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);  wait_done();
        issue(7, -32'sd2, 1'b1, 32'hFFFF_FFFD, 1, 1'b0);              wait_done();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 0, 1'b0); wait_done();
        issue(32'hFFFF_FFFF, 1, 1'b0, 32'hFFFF_FFFF, 0, 1'b0);       wait_done();
        issue(5, 0, 1'b0, 32'hFFFF_FFFF, 5, 1'b0 | 1'b1);             wait_done();
        issue(5, 0, 1'b1, 32'hFFFF_FFFF, 5, 1'b1);                    wait_done();
        issue(-32'sd5, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);  wait_done();
        issue(0, 9, 1'b1, 0, 0, 1'b0);                                wait_done();
        @(negedge clk);

        // Request during busy is dropped; request in the done cycle is taken.
        issue(100, 7, 1'b0, 14, 2, 1'b0);
        repeat (9) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 9; bus.divisor = 3; bus.is_signed = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        issue(9, 3, 1'b0, 3, 0, 1'b0);
        wait_done();
        @(negedge clk);

        // Reset mid-operation aborts with no done pulse.
        issue(1000, 3, 1'b0, 333, 1, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        check("abort_busy", bus.busy, 0);
        check("abort_quotient", bus.quotient, 0);
        check("abort_remainder", bus.remainder, 0);
        check("abort_dz", bus.div_by_zero, 0);
        repeat (WIDTH + 4) begin
            @(negedge clk);
            check("abort_no_done", bus.done, 0);
        end
        issue(100, 7, 1'b0, 14, 2, 1'b0);
        wait_done();

        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? WIDTH'($urandom_range(0, 20)) : WIDTH'($urandom);
            if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 30);
            issue_model(a, b, 1'($urandom_range(0, 1)));
            wait_done();
            if (i % 3 == 0) repeat (2) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
